// File: rtl/fp16_accumulator.sv
// FP16 running-sum stage: ALIGN/ADD/NORM add FSM, truncating, emits the group sum on a last-tagged word.
// Latency 4 cycles per product; in_ready stays low while the FSM is busy or an unaccepted result is held.
module fp16_accumulator #(
  parameter logic [15:0] NAN_CODE = 16'h7E00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

  state_t      state_q, state_d;
  logic        open_q, open_d;
  logic [15:0] in_dat_q, in_dat_d;
  logic        last_q, last_d;
  logic [15:0] acc_q, acc_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic        special_q, special_d;
  logic [15:0] special_val_q, special_val_d;
  logic        sign_a_q, sign_a_d;
  logic        eff_sub_q, eff_sub_d;
  logic [4:0]  exp_a_q, exp_a_d;
  logic [10:0] mant_a_q, mant_a_d;
  logic [10:0] mant_b_q, mant_b_d;
  logic [11:0] sum_q, sum_d;
  logic        xfer;

  function automatic logic [3:0] lzc11(input logic [10:0] v);
    lzc11 = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (v[i]) lzc11 = 4'(10 - i);
    end
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // open_q keeps in_ready low until the first clock edge after reset release.
  always_comb begin
    in_ready = open_q && (state_q == IDLE) && !(out_valid_q && !out_ready);
    busy     = (state_q != IDLE);
    xfer     = in_valid && in_ready;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // ---------------- ALIGN: unpack, classify, swap, shift ----------------
  logic        acc_s, inp_s;
  logic [4:0]  acc_e, inp_e;
  logic [9:0]  acc_f, inp_f;
  logic        acc_nan, inp_nan, acc_inf, inp_inf;
  logic [10:0] acc_m, inp_m;
  logic        acc_sz, inp_sz;
  logic        swap;
  logic [4:0]  exp_b, shamt;
  logic [10:0] mant_small;
  logic [3:0]  shamt_c;

  always_comb begin
    {acc_s, acc_e, acc_f} = acc_q;
    {inp_s, inp_e, inp_f} = in_dat_q;
    acc_nan = (acc_e == 5'h1F) && (acc_f != 10'd0);
    inp_nan = (inp_e == 5'h1F) && (inp_f != 10'd0);
    acc_inf = (acc_e == 5'h1F) && (acc_f == 10'd0);
    inp_inf = (inp_e == 5'h1F) && (inp_f == 10'd0);
    // Zero and subnormal operands collapse to +0.
    acc_m  = (acc_e == 5'd0) ? 11'd0 : {1'b1, acc_f};
    inp_m  = (inp_e == 5'd0) ? 11'd0 : {1'b1, inp_f};
    acc_sz = (acc_e == 5'd0) ? 1'b0 : acc_s;
    inp_sz = (inp_e == 5'd0) ? 1'b0 : inp_s;
    swap   = (inp_e > acc_e) || ((inp_e == acc_e) && (inp_m > acc_m));

    sign_a_d      = sign_a_q;
    eff_sub_d     = eff_sub_q;
    exp_a_d       = exp_a_q;
    mant_a_d      = mant_a_q;
    mant_b_d      = mant_b_q;
    special_d     = special_q;
    special_val_d = special_val_q;

    exp_b      = swap ? acc_e : inp_e;
    mant_small = swap ? acc_m : inp_m;
    shamt      = (swap ? inp_e : acc_e) - exp_b;
    shamt_c    = (shamt > 5'd13) ? 4'd13 : shamt[3:0];

    if (state_q == ALIGN) begin
      sign_a_d  = swap ? inp_sz : acc_sz;
      eff_sub_d = (acc_sz != inp_sz);
      exp_a_d   = swap ? inp_e : acc_e;
      mant_a_d  = swap ? inp_m : acc_m;
      mant_b_d  = mant_small >> shamt_c;
      special_d = acc_nan || inp_nan || acc_inf || inp_inf;
      if (acc_nan || inp_nan || (acc_inf && inp_inf && (acc_s != inp_s))) begin
        special_val_d = NAN_CODE;
      end else if (acc_inf) begin
        special_val_d = acc_q;
      end else begin
        special_val_d = in_dat_q;
      end
    end
  end

  // ---------------- ADD ----------------
  always_comb begin
    sum_d = sum_q;
    if (state_q == ADD) begin
      // Operand A is never smaller than the aligned B, so subtraction cannot wrap.
      sum_d = eff_sub_q ? ({1'b0, mant_a_q} - {1'b0, mant_b_q})
                        : ({1'b0, mant_a_q} + {1'b0, mant_b_q});
    end
  end

  // ---------------- NORM and result packing ----------------
  logic [3:0]        lz;
  logic signed [6:0] exp_n;
  logic [9:0]        frac_n;
  logic [15:0]       result;

  always_comb begin
    lz = lzc11(sum_q[10:0]);
    if (sum_q[11]) begin
      exp_n  = $signed({2'b00, exp_a_q}) + 7'sd1;
      frac_n = sum_q[10:1];
    end else begin
      exp_n  = $signed({2'b00, exp_a_q}) - $signed({3'b000, lz});
      // Dropping bit 10 after the shift removes the hidden 1.
      frac_n = sum_q[9:0] << lz;
    end

    if (special_q) begin
      result = special_val_q;
    end else if (sum_q == 12'd0) begin
      result = 16'h0000;
    end else if (exp_n > 7'sd30) begin
      result = {sign_a_q, 5'h1F, 10'h000};
    end else if (exp_n < 7'sd1) begin
      result = 16'h0000;
    end else begin
      result = {sign_a_q, exp_n[4:0], frac_n};
    end
  end

  // ---------------- Input latch, accumulator, output hold ----------------
  always_comb begin
    open_d      = 1'b1;
    in_dat_d    = in_dat_q;
    last_d      = last_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (xfer) begin
      in_dat_d = in_data;
      last_d   = in_last;
    end
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (state_q == NORM) begin
      acc_d = last_q ? 16'h0000 : result;
      if (last_q) begin
        out_valid_d = 1'b1;
        out_data_d  = result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q        <= 1'b0;
      in_dat_q      <= 16'h0000;
      last_q        <= 1'b0;
      acc_q         <= 16'h0000;
      out_valid_q   <= 1'b0;
      out_data_q    <= 16'h0000;
      special_q     <= 1'b0;
      special_val_q <= 16'h0000;
      sign_a_q      <= 1'b0;
      eff_sub_q     <= 1'b0;
      exp_a_q       <= 5'd0;
      mant_a_q      <= 11'd0;
      mant_b_q      <= 11'd0;
      sum_q         <= 12'd0;
    end else begin
      open_q        <= open_d;
      in_dat_q      <= in_dat_d;
      last_q        <= last_d;
      acc_q         <= acc_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      special_q     <= special_d;
      special_val_q <= special_val_d;
      sign_a_q      <= sign_a_d;
      eff_sub_q     <= eff_sub_d;
      exp_a_q       <= exp_a_d;
      mant_a_q      <= mant_a_d;
      mant_b_q      <= mant_b_d;
      sum_q         <= sum_d;
    end
  end

endmodule

// File: tb/tb_fp16_accumulator.sv
// Scoreboarded bench for fp16_accumulator: directed corner groups plus randomized groups vs. an integer reference model.
module tb_fp16_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;

  fp16_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  int          rdy_mode = 0;  // 0: always ready, 1: random stalls, 2: never ready
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic following the alignment/truncation rules.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, sa, sb, d, s, e, t;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0)) return 16'h7E00;
    if (ea == 31 && eb == 31 && a[15] != b[15]) return 16'h7E00;
    if (ea == 31) return a;
    if (eb == 31) return b;
    ma = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
    mb = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
    sa = (ea == 0) ? 0 : int'(a[15]);
    sb = (eb == 0) ? 0 : int'(b[15]);
    if (ea < eb || (ea == eb && ma < mb)) begin
      t = ea; ea = eb; eb = t;
      t = ma; ma = mb; mb = t;
      t = sa; sa = sb; sb = t;
    end
    d = ea - eb;
    if (d > 13) d = 13;
    mb = mb >> d;
    s = (sa == sb) ? ma + mb : ma - mb;
    if (s == 0) return 16'h0000;
    e = ea;
    while (s >= 2048) begin s = s / 2; e++; end
    while (s < 1024) begin s = s * 2; e--; end
    if (e > 30) return {sa[0], 15'h7C00};
    if (e < 1) return 16'h0000;
    return {sa[0], e[4:0], s[9:0]};
  endfunction

  function automatic logic [15:0] rand_fp();
    int r;
    logic [15:0] v;
    r = $urandom_range(0, 63);
    v = 16'($urandom);
    if (r == 0)      v[14:10] = 5'd0;
    else if (r == 1) v[14:0] = 15'h7C00;
    else if (r == 2) begin v[14:10] = 5'h1F; v[9] = 1'b1; end
    else if (r < 8)  v[14:10] = 5'($urandom_range(27, 30));
    else             v[14:10] = 5'($urandom_range(10, 20));
    return v;
  endfunction

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted output and checks hold stability.
  initial begin
    logic        prev_hold;
    logic [15:0] prev_dat;
    prev_hold = 1'b0;
    prev_dat  = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", 16'(out_valid), 16'h1);
          check("hold_data", out_data, prev_dat);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_output: got %h, expected no output at t=%0t", out_data, $time);
          end else begin
            check("out_data", out_data, exp_q.pop_front());
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_dat  = out_data;
      end
    end
  end

  // Call at posedge+#1; returns at posedge+#1 after the transfer edge.
  task automatic send(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'($urandom); in_last = 1'($urandom);
  endtask

  // Cycles 1..3 after a transfer the FSM is busy; cycle 4 it is idle (result visible).
  task automatic check_latency(input logic last);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("lat_busy", 16'(busy), 16'h1);
      check("lat_in_ready_low", 16'(in_ready), 16'h0);
      if (last) check("lat_out_valid_early", 16'(out_valid), 16'h0);
    end
    @(negedge clk);
    check("lat_idle", 16'(busy), 16'h0);
    check("lat_in_ready_back", 16'(in_ready), 16'h1);
    if (last) check("lat_out_valid", 16'(out_valid), 16'h1);
    @(posedge clk); #1;
  endtask

  task automatic group2(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    exp_q.push_back(exp);
    send(a, 1'b0); check_latency(1'b0);
    send(b, 1'b1); check_latency(1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] acc, w;
    int len;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", 16'(in_ready), 16'h0);
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_busy", 16'(busy), 16'h0);
    #2 rst_n = 1'b1;
    #1 check("rel_in_ready_before_edge", 16'(in_ready), 16'h0);
    @(posedge clk); #1;
    check("rel_in_ready_after_edge", 16'(in_ready), 16'h1);

    // 1.0 + 2.0 = 3.0
    group2(16'h3C00, 16'h4000, 16'h4200);

    // 1.0 x4 = 4.0
    exp_q.push_back(16'h4400);
    for (int i = 0; i < 4; i++) begin
      send(16'h3C00, (i == 3));
      check_latency(i == 3);
    end

    group2(16'h3C00, 16'hBC00, 16'h0000);
    group2(16'h6800, 16'h3C00, 16'h6800);
    group2(16'h7BFF, 16'h7BFF, 16'h7C00);
    group2(16'h7C00, 16'hFC00, 16'h7E00);
    group2(16'h0001, 16'h3800, 16'h3800);
    group2(16'hC000, 16'h3C00, 16'hBC00);

    // Output hold with out_ready low
    rdy_mode = 2;
    repeat (2) @(posedge clk); #1;
    exp_q.push_back(16'h4000);
    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b1);
    n = 0;
    while (!out_valid && n < 10) begin @(negedge clk); n++; end
    check("hold_out_valid_seen", 16'(out_valid), 16'h1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h5555; in_last = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_in_ready", 16'(in_ready), 16'h0);
      check("hold_valid_dir", 16'(out_valid), 16'h1);
      check("hold_data_dir", out_data, 16'h4000);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    rdy_mode = 0;
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && n < 5) begin @(negedge clk); n++; end
    check("hold_accepted", 16'(out_valid && out_ready), 16'h1);
    @(negedge clk);
    check("post_accept_in_ready", 16'(in_ready), 16'h1);
    check("post_accept_out_valid", 16'(out_valid), 16'h0);
    check("post_accept_busy", 16'(busy), 16'h0);
    @(posedge clk); #1;

    // Reset during ADD of a last-tagged word
    send(16'h3C00, 1'b0); check_latency(1'b0);
    send(16'h4000, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 16'(out_valid), 16'h0);
    check("midrst_in_ready", 16'(in_ready), 16'h0);
    check("midrst_busy", 16'(busy), 16'h0);
    check("midrst_out_data", out_data, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("midrst_no_output", 16'(out_valid), 16'h0);
    end
    @(posedge clk); #1;
    exp_q.push_back(16'h3C00);
    send(16'h3C00, 1'b1); check_latency(1'b1);

    // Randomized groups with random output stalls
    rdy_mode = 1;
    for (int g = 0; g < 60; g++) begin
      len = $urandom_range(1, 5);
      acc = 16'h0000;
      for (int i = 0; i < len; i++) begin
        w = rand_fp();
        acc = ref_add(acc, w);
        if (i == len - 1) exp_q.push_back(acc);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
        send(w, (i == len - 1));
      end
    end

    rdy_mode = 0;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin @(negedge clk); n++; end
    check("drain_queue_empty", 16'(exp_q.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
